wb_arbiter_2m: RTL and testbench

Two-master, one-slave Wishbone B4 pipelined arbiter. It shares a single slave port (e.g. port1 of memory_2rw_wb, or the peripheral decode fabric) between the core data bus and a second bus master such as the UART loader or a DMA. A grant is held for a master's whole cycle (cyc high); masters are served round-robin. Outstanding requests are tracked, and a watchdog terminates hung transfers with err.

---
 rtl/wb_arbiter_2m.sv | 146 ++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone B4 pipelined arbiter.
// A grant is held for the whole master cycle, ties are broken round-robin,
// accepted-but-unacknowledged requests are counted and a watchdog turns a
// hung transfer into an err towards the granted master.
module wb_arbiter_2m #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        m0_wb_cyc_i,
   input  logic        m0_wb_stb_i,
   input  logic        m0_wb_we_i,
   input  logic [31:0] m0_wb_adr_i,
   input  logic [31:0] m0_wb_dat_i,
   input  logic [3:0]  m0_wb_sel_i,
   output logic        m0_wb_stall_o,
   output logic        m0_wb_ack_o,
   output logic        m0_wb_err_o,
   output logic [31:0] m0_wb_dat_o,
   input  logic        m1_wb_cyc_i,
   input  logic        m1_wb_stb_i,
   input  logic        m1_wb_we_i,
   input  logic [31:0] m1_wb_adr_i,
   input  logic [31:0] m1_wb_dat_i,
   input  logic [3:0]  m1_wb_sel_i,
   output logic        m1_wb_stall_o,
   output logic        m1_wb_ack_o,
   output logic        m1_wb_err_o,
   output logic [31:0] m1_wb_dat_o,
   output logic        s_wb_cyc_o,
   output logic        s_wb_stb_o,
   output logic        s_wb_we_o,
   output logic [31:0] s_wb_adr_o,
   output logic [31:0] s_wb_dat_o,
   output logic [3:0]  s_wb_sel_o,
   input  logic        s_wb_stall_i,
   input  logic        s_wb_ack_i,
   input  logic        s_wb_err_i,
   input  logic [31:0] s_wb_dat_i,
   output logic [1:0]  grant_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wb_req_t;

   localparam int              TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [3:0]      MAX_OUT = 4'(MAX_OUTSTANDING);
   localparam logic [TW-1:0]   T_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t        state;
   logic          last_grant;   // 0: m0 was granted last, 1: m1
   logic [3:0]    outstanding;
   logic [TW-1:0] timer;

   wb_req_t req0, req1, req;
   logic    granted, full, accept, done, timeout_err;

   assign req0 = {m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i, m0_wb_adr_i, m0_wb_dat_i, m0_wb_sel_i};
   assign req1 = {m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i, m1_wb_adr_i, m1_wb_dat_i, m1_wb_sel_i};
   assign req  = (state == GNT1) ? req1 : req0;

   assign granted = (state == GNT0) || (state == GNT1);
   assign full    = (outstanding == MAX_OUT);
   assign grant_o = {state == GNT1, state == GNT0};

   // Slave side is a pure decode of the state register plus the granted master.
   assign s_wb_cyc_o = granted & req.cyc;
   assign s_wb_stb_o = granted & req.stb & ~full;
   assign s_wb_we_o  = granted & req.we;
   assign s_wb_adr_o = granted ? req.adr : '0;
   assign s_wb_dat_o = granted ? req.dat : '0;
   assign s_wb_sel_o = granted ? req.sel : '0;

   assign accept = s_wb_stb_o & ~s_wb_stall_i;
   assign done   = s_wb_ack_i | s_wb_err_i | timeout_err;

   // Watchdog fires on the last quiet cycle; a real ack/err in that cycle wins.
   if (TIMEOUT_CYCLES > 0) begin : g_wd
      assign timeout_err = granted && (outstanding != 4'd0) && !s_wb_ack_i && !s_wb_err_i
                           && (timer == T_LAST);
   end else begin : g_no_wd
      assign timeout_err = 1'b0;
   end

   // Master responses: only the granted master sees the slave; the other is stalled.
   assign m0_wb_stall_o = (state == GNT0) ? (s_wb_stall_i | full) : 1'b1;
   assign m0_wb_ack_o   = (state == GNT0) & s_wb_ack_i;
   assign m0_wb_err_o   = (state == GNT0) & (s_wb_err_i | timeout_err);
   assign m0_wb_dat_o   = (state == GNT0) ? s_wb_dat_i : '0;
   assign m1_wb_stall_o = (state == GNT1) ? (s_wb_stall_i | full) : 1'b1;
   assign m1_wb_ack_o   = (state == GNT1) & s_wb_ack_i;
   assign m1_wb_err_o   = (state == GNT1) & (s_wb_err_i | timeout_err);
   assign m1_wb_dat_o   = (state == GNT1) ? s_wb_dat_i : '0;

   // Grant FSM with outstanding counter and watchdog timer.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         outstanding <= '0;
         timer       <= '0;
      end else begin
         case (state)
            IDLE: begin
               outstanding <= '0;
               timer       <= '0;
               if (m0_wb_cyc_i && (!m1_wb_cyc_i || last_grant)) begin
                  state      <= GNT0;
                  last_grant <= 1'b0;
               end else if (m1_wb_cyc_i) begin
                  state      <= GNT1;
                  last_grant <= 1'b1;
               end
            end
            GNT0, GNT1: begin
               if (!req.cyc) begin
                  // Release (also a Wishbone abort): late acks land in IDLE and are dropped.
                  state       <= IDLE;
                  outstanding <= '0;
                  timer       <= '0;
               end else begin
                  if (accept && !done)
                     outstanding <= outstanding + 4'd1;
                  else if (!accept && done && (outstanding != 4'd0))
                     outstanding <= outstanding - 4'd1;
                  if (done || (outstanding == 4'd0))
                     timer <= '0;
                  else
                     timer <= timer + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: a per-cycle vector table for grant and
// handshake behaviour, then hand-written sequences for outstanding limit,
// watchdog timeout and asynchronous reset mid-transfer.
module tb_wb_arbiter_2m;

   localparam logic [31:0] A0 = 32'h0000_7400, D0 = 32'h1111_1111;
   localparam logic [31:0] A1 = 32'h0000_8000, D1 = 32'h2222_2222;
   localparam logic [31:0] SD = 32'hDEAD_BEEF;

   logic        clk = 1'b0, rst = 1'b0;
   logic        m0_cyc = 0, m0_stb = 0, m1_cyc = 0, m1_stb = 0;
   logic        m0_we = 1'b0, m1_we = 1'b1;
   logic [31:0] m0_adr = A0, m0_dat = D0, m1_adr = A1, m1_dat = D1;
   logic [3:0]  m0_sel = 4'hF, m1_sel = 4'h3;
   logic        m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
   logic [31:0] m0_rdat, m1_rdat;
   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_adr, s_wdat;
   logic [3:0]  s_sel;
   logic        s_stall = 0, s_ack = 0, s_err = 0;
   logic [31:0] s_rdat = SD;
   logic [1:0]  grant;

   int n_chk = 0, n_fail = 0;

   wb_arbiter_2m #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
      .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
      .m0_wb_stall_o(m0_stall), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err), .m0_wb_dat_o(m0_rdat),
      .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
      .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
      .m1_wb_stall_o(m1_stall), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err), .m1_wb_dat_o(m1_rdat),
      .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
      .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel),
      .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err), .s_wb_dat_i(s_rdat),
      .grant_o(grant)
   );

   always #5 clk = ~clk;

   // in: {rst, c0, s0, c1, s1, s_stall, s_ack, s_err}
   // ex: {grant[1:0], s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err}
   typedef struct {
      logic [7:0] in;
      logic [9:0] ex;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [7:0] in, input logic [9:0] ex);
      vec_t v;
      v.in = in;
      v.ex = ex;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   localparam logic [9:0] IDL = 10'b00_00_11_00_00;

   initial begin
      logic [191:0] exp_dp;
      int mdl_out, issued, acks, pre_ack, n_err, cyc_n;
      int ack_due[$];
      logic exp_full, acc;

      // single read by m0
      add(8'b1_00_00_000, IDL);
      add(8'b0_00_00_000, IDL);
      add(8'b0_11_00_000, IDL);
      add(8'b0_11_00_000, 10'b01_11_01_00_00);
      add(8'b0_10_00_010, 10'b01_10_01_10_00);
      add(8'b0_00_00_000, 10'b01_00_01_00_00);
      add(8'b0_00_00_000, IDL);
      // simultaneous requests: m0, dead cycle, then a new tie goes to m1
      add(8'b1_00_00_000, IDL);
      add(8'b0_11_11_000, IDL);
      add(8'b0_11_11_000, 10'b01_11_01_00_00);
      add(8'b0_10_11_010, 10'b01_10_01_10_00);
      add(8'b0_00_11_000, 10'b01_00_01_00_00);
      add(8'b0_11_11_000, IDL);
      add(8'b0_11_11_000, 10'b10_11_10_00_00);
      add(8'b0_11_10_010, 10'b10_10_10_01_00);
      add(8'b0_11_00_000, 10'b10_00_10_00_00);
      add(8'b0_11_00_000, IDL);
      add(8'b0_11_00_100, 10'b01_11_11_00_00);
      add(8'b0_11_00_000, 10'b01_11_01_00_00);
      add(8'b0_10_00_001, 10'b01_10_01_00_10);
      add(8'b0_00_00_000, 10'b01_00_01_00_00);
      add(8'b0_00_00_000, IDL);
      // m0 aborts with 2 outstanding; stale ack dropped in IDLE, m1 granted next
      add(8'b0_11_00_000, IDL);
      add(8'b0_11_11_000, 10'b01_11_01_00_00);
      add(8'b0_11_11_000, 10'b01_11_01_00_00);
      add(8'b0_00_11_000, 10'b01_00_01_00_00);
      add(8'b0_00_11_010, IDL);
      add(8'b0_00_11_000, 10'b10_11_10_00_00);
      add(8'b0_00_10_010, 10'b10_10_10_01_00);
      add(8'b0_00_00_000, 10'b10_00_10_00_00);
      add(8'b0_00_00_000, IDL);

      foreach (vecs[i]) begin
         @(negedge clk);
         {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_stall, s_ack, s_err} = vecs[i].in;
         #1;
         chk($sformatf("vec%0d_ctl", i),
             192'({grant, s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err}),
             192'(vecs[i].ex));
         case (vecs[i].ex[9:8])
            2'b01:   exp_dp = 192'({A0, D0, 4'hF, 1'b0, SD, 32'h0});
            2'b10:   exp_dp = 192'({A1, D1, 4'h3, 1'b1, 32'h0, SD});
            default: exp_dp = '0;
         endcase
         chk($sformatf("vec%0d_data", i), 192'({s_adr, s_wdat, s_sel, s_we, m0_rdat, m1_rdat}), exp_dp);
      end

      // m1: 6 back-to-back requests, acks 8 cycles after acceptance, limit of 4
      @(negedge clk);
      {rst, m0_cyc, m0_stb, s_stall, s_ack, s_err} = '0;
      m1_cyc = 1'b1; m1_stb = 1'b0;
      #1 chk("burst_idle_grant", 192'(grant), 192'(2'b00));
      mdl_out = 0; issued = 0; acks = 0; pre_ack = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         s_ack  = (ack_due.size() > 0) && (ack_due[0] == c);
         m1_stb = (issued < 6);
         #1;
         exp_full = (mdl_out == 4);
         acc = m1_stb && !exp_full;
         chk($sformatf("burst_stall_c%0d", c), 192'(m1_stall), 192'(exp_full));
         chk($sformatf("burst_sstb_c%0d", c), 192'(s_stb), 192'(acc));
         if (acc) begin
            issued++;
            ack_due.push_back(c + 8);
            if (acks == 0) pre_ack++;
         end
         if (m1_ack) acks++;
         if (s_ack) void'(ack_due.pop_front());
         mdl_out = mdl_out + int'(acc) - int'(s_ack);
         if (acks == 6) break;
      end
      chk("burst_acks", 192'(acks), 192'(6));
      chk("burst_pre_ack_accepts", 192'(pre_ack), 192'(4));
      @(negedge clk);
      {m1_cyc, m1_stb, s_ack} = '0;
      @(negedge clk);

      // m0: one request, slave silent -> watchdog err 16 cycles after accept
      m0_cyc = 1'b1; m0_stb = 1'b0;
      @(negedge clk);
      m0_stb = 1'b1;
      #1 chk("wd_accept", 192'({grant, s_stb, m0_stall}), 192'({2'b01, 1'b1, 1'b0}));
      n_err = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         m0_stb = 1'b0;
         #1;
         if (m0_err) begin
            n_err = k;
            break;
         end
      end
      chk("wd_err_delay", 192'(n_err), 192'(16));
      @(negedge clk);
      #1 chk("wd_err_pulse_width", 192'(m0_err), 192'(0));
      // counter back at 0: four more accepts fit, the fifth stalls
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         m0_stb = 1'b1;
         #1 chk($sformatf("wd_refill%0d", j), 192'(m0_stall), 192'(j == 4));
      end
      @(negedge clk);
      {m0_cyc, m0_stb} = '0;
      @(negedge clk);

      // m1 with 3 outstanding, async reset mid-transfer
      m1_cyc = 1'b1; m1_stb = 1'b1;
      cyc_n = 0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         #1 if (s_stb && !s_stall) cyc_n++;
      end
      chk("rst_pre_accepts", 192'({grant, 2'(cyc_n)}), 192'({2'b10, 2'd3}));
      @(negedge clk);
      m1_stb = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1; rst = 1'b1;
      #1 chk("rst_async_grant", 192'(grant), 192'(2'b00));
      chk("rst_async_scyc", 192'(s_cyc), 192'(0));
      chk("rst_async_stalls", 192'({m0_stall, m1_stall}), 192'(2'b11));
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_release_idle", 192'(grant), 192'(2'b00));
      @(negedge clk);
      #1 chk("rst_tie_m0_wins", 192'(grant), 192'(2'b01));
      @(negedge clk);
      {m0_cyc, m0_stb, m1_cyc, m1_stb} = '0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
